map_align_ctrl: RTL and testbench



---
 rtl/map_align_ctrl.sv | 168 ++++++++++++++++
 tb/tb_map_align_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/map_align_ctrl.sv
// Bit-order alignment controller: steers the mapping-stage bypass select until TRAIN_WORD is seen.
// Latency: all outputs registered; lock declared on the edge of the LOCK_CNT-th consecutive match.
// Backpressure: none; map_dout is sampled every cycle and never stalled.
module map_align_ctrl #(
  parameter logic [31:0] TRAIN_WORD   = 32'hBC3C_5A96,
  parameter int          LOCK_CNT     = 8,
  parameter int          UNLOCK_CNT   = 4,
  parameter int          SETTLE       = 2,
  parameter int          TIMEOUT      = 64,
  parameter int          MAX_ATTEMPTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        train_mode,
  input  logic [31:0] map_dout,
  output logic        bypass,
  output logic        locked,
  output logic        align_err,
  output logic [2:0]  state_dbg,
  output logic [2:0]  attempts
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);
  localparam logic [MW-1:0] LOCK_MAX   = MW'(LOCK_CNT);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
  localparam logic [UW-1:0] UNLOCK_MAX = UW'(UNLOCK_CNT);
  localparam logic [AW-1:0] ATT_MAX    = AW'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_HUNT   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [UW-1:0] miss_q, miss_d;
  logic [AW-1:0] att_q, att_d;
  logic          bypass_q, bypass_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          is_match;

  assign is_match = (map_dout == TRAIN_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      match_q  <= '0;
      tmo_q    <= '0;
      miss_q   <= '0;
      att_q    <= '0;
      bypass_q <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      tmo_q    <= tmo_d;
      miss_q   <= miss_d;
      att_q    <= att_d;
      bypass_q <= bypass_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    tmo_d    = tmo_q;
    miss_d   = miss_q;
    att_d    = att_q;
    bypass_d = bypass_q;
    locked_d = locked_q;
    err_d    = err_q;

    if (!enable) begin
      // bypass is deliberately kept so a re-enable resumes with the last good mapping
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          locked_d = 1'b0;
          err_d    = 1'b0;
          settle_d = '0;
          att_d    = '0;
          state_d  = ST_SETTLE;
        end

        ST_SETTLE: begin
          settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 1'b1;
          if (settle_d == SETTLE_MAX) begin
            match_d = '0;
            tmo_d   = '0;
            state_d = ST_HUNT;
          end
        end

        ST_HUNT: begin
          match_d = !is_match ? '0 : (match_q == LOCK_MAX) ? match_q : match_q + 1'b1;
          tmo_d   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
          // a lock completing on the timeout edge wins over the toggle
          if (match_d == LOCK_MAX) begin
            locked_d = 1'b1;
            miss_d   = '0;
            state_d  = ST_LOCKED;
          end else if (tmo_d == TMO_MAX) begin
            att_d = (att_q == ATT_MAX) ? att_q : att_q + 1'b1;
            if (att_d == ATT_MAX) begin
              err_d   = 1'b1;
              state_d = ST_FAIL;
            end else begin
              bypass_d = ~bypass_q;
              settle_d = '0;
              state_d  = ST_SETTLE;
            end
          end
        end

        ST_LOCKED: begin
          if (!train_mode) begin
            miss_d = '0;
          end else begin
            miss_d = is_match ? '0 : (miss_q == UNLOCK_MAX) ? miss_q : miss_q + 1'b1;
            // relock hunts on the current mapping without re-settling
            if (miss_d == UNLOCK_MAX) begin
              locked_d = 1'b0;
              match_d  = '0;
              tmo_d    = '0;
              state_d  = ST_HUNT;
            end
          end
        end

        ST_FAIL: begin
          err_d    = 1'b1;
          locked_d = 1'b0;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bypass    = bypass_q;
  assign locked    = locked_q;
  assign align_err = err_q;
  assign state_dbg = state_q;
  assign attempts  = 3'(att_q);

endmodule

// File: tb/tb_map_align_ctrl.sv
// Bench for map_align_ctrl looped through a registered bit-reverse mapping stage;
// expected snapshots are queued with the edge they apply to and compared after that edge.
module tb_map_align_ctrl;

  localparam logic [31:0] TW = 32'hBC3C_5A96;
  localparam int S_IDLE = 0, S_SETTLE = 1, S_HUNT = 2, S_LOCKED = 3, S_FAIL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        train_mode;
  logic [31:0] raw;
  logic [31:0] map_dout;
  logic        bypass;
  logic        locked;
  logic        align_err;
  logic [2:0]  state_dbg;
  logic [2:0]  attempts;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    string tag;
    int    due;
    int    st;
    int    byp;
    int    lck;
    int    err;
    int    att;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  map_align_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .train_mode (train_mode),
    .map_dout   (map_dout),
    .bypass     (bypass),
    .locked     (locked),
    .align_err  (align_err),
    .state_dbg  (state_dbg),
    .attempts   (attempts)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  // paired mapping stage: one register, straight when bypass=1, bit-reversed otherwise
  always_ff @(posedge clk) map_dout <= bypass ? raw : rev32(raw);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input string tag, input int due, input int st, input int byp,
                           input int lck, input int err, input int att);
    exp_t x;
    x.tag = tag; x.due = due; x.st = st; x.byp = byp; x.lck = lck; x.err = err; x.att = att;
    sbq.push_back(x);
  endtask

  // att < 0 means attempts is not compared for that snapshot
  always @(posedge clk) begin
    #1;
    while (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check_val({e.tag, ".late"}, 32'(cyc), 32'(e.due));
      check_val({e.tag, ".state"}, 32'(state_dbg), 32'(e.st));
      check_val({e.tag, ".bypass"}, 32'(bypass), 32'(e.byp));
      check_val({e.tag, ".locked"}, 32'(locked), 32'(e.lck));
      check_val({e.tag, ".align_err"}, 32'(align_err), 32'(e.err));
      if (e.att >= 0) check_val({e.tag, ".attempts"}, 32'(attempts), 32'(e.att));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k, c;
    rst = 1'b1; enable = 1'b0; train_mode = 1'b1; raw = '0;
    tick(2);
    expect_at("reset", cyc + 1, S_IDLE, 0, 0, 0, 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // straight match through the reverse map
    raw = rev32(TW);
    tick(3);
    k = cyc + 1; enable = 1'b1;
    expect_at("straight_settled", k + 2, S_HUNT, 0, 0, 0, 0);
    expect_at("straight_prelock", k + 9, S_HUNT, 0, 0, 0, 0);
    expect_at("straight_lock", k + 10, S_LOCKED, 0, 1, 0, 0);
    tick(11);

    // three misses then a match keeps lock
    c = cyc; raw = '0;
    expect_at("miss3", c + 4, S_LOCKED, 0, 1, 0, 0);
    expect_at("miss3_recover", c + 6, S_LOCKED, 0, 1, 0, 0);
    tick(3); raw = rev32(TW); tick(4);

    // four misses drop lock straight into HUNT, then relock
    c = cyc;
    expect_at("miss4_hold", c + 4, S_LOCKED, 0, 1, 0, 0);
    expect_at("miss4_drop", c + 5, S_HUNT, 0, 0, 0, 0);
    expect_at("relock_pre", c + 12, S_HUNT, 0, 0, 0, 0);
    expect_at("relock", c + 13, S_LOCKED, 0, 1, 0, 0);
    raw = '0; tick(4); raw = rev32(TW); tick(10);

    // payload words with train_mode=0 never drop lock
    c = cyc; train_mode = 1'b0;
    for (int i = 0; i < 20; i++) expect_at("payload", c + 2 + i, S_LOCKED, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      raw = $urandom;
      tick(1);
    end
    raw = rev32(TW); tick(3);
    train_mode = 1'b1;
    expect_at("payload_end", cyc + 2, S_LOCKED, 0, 1, 0, 0);
    tick(2);
    c = cyc; enable = 1'b0;
    expect_at("disable_a", c + 1, S_IDLE, 0, 0, 0, 0);
    tick(2);

    // verbatim word: only the straight path matches, reached after one timeout
    raw = TW; tick(3);
    k = cyc + 1; enable = 1'b1;
    expect_at("toggle_pre", k + 65, S_HUNT, 0, 0, 0, 0);
    expect_at("toggle", k + 66, S_SETTLE, 1, 0, 0, 1);
    expect_at("toggle_hunt", k + 68, S_HUNT, 1, 0, 0, 1);
    expect_at("toggle_prelock", k + 75, S_HUNT, 1, 0, 0, 1);
    expect_at("toggle_lock", k + 76, S_LOCKED, 1, 1, 0, 1);
    tick(77);
    c = cyc; enable = 1'b0;
    expect_at("disable_b", c + 1, S_IDLE, 1, 0, 0, -1);
    tick(2);

    rst = 1'b1;
    expect_at("rst_idle", cyc + 1, S_IDLE, 0, 0, 0, 0);
    tick(1); rst = 1'b0; tick(1);

    // no match at all: three toggles then FAIL
    raw = '0; tick(3);
    k = cyc + 1; enable = 1'b1;
    expect_at("nomatch_t1", k + 66, S_SETTLE, 1, 0, 0, 1);
    expect_at("nomatch_t2", k + 132, S_SETTLE, 0, 0, 0, 2);
    expect_at("nomatch_t3", k + 198, S_SETTLE, 1, 0, 0, 3);
    expect_at("nomatch_prefail", k + 263, S_HUNT, 1, 0, 0, 3);
    expect_at("nomatch_fail", k + 264, S_FAIL, 1, 0, 1, 4);
    expect_at("fail_sticky", k + 274, S_FAIL, 1, 0, 1, 4);
    tick(275);
    c = cyc; enable = 1'b0;
    expect_at("fail_clear", c + 1, S_IDLE, 1, 0, 0, -1);
    tick(2);

    // eighth match lands on the timeout edge: lock wins, no toggle
    raw = '0; tick(3);
    k = cyc + 1; enable = 1'b1;
    expect_at("simul_pre", k + 65, S_HUNT, 1, 0, 0, 0);
    expect_at("simul_lock", k + 66, S_LOCKED, 1, 1, 0, 0);
    expect_at("simul_hold", k + 70, S_LOCKED, 1, 1, 0, 0);
    tick(58); raw = TW; tick(14);
    enable = 1'b0; tick(2);

    // reset mid-HUNT with bypass=1, then enable drop mid-SETTLE
    raw = '0; tick(3);
    k = cyc + 1; enable = 1'b1;
    expect_at("midrst_pre", k + 31, S_HUNT, 1, 0, 0, 0);
    expect_at("midrst", k + 32, S_IDLE, 0, 0, 0, 0);
    expect_at("midrst_restart", k + 33, S_SETTLE, 0, 0, 0, 0);
    expect_at("midsettle_pre", k + 99, S_SETTLE, 1, 0, 0, 1);
    expect_at("midsettle_off", k + 100, S_IDLE, 1, 0, 0, -1);
    tick(32); rst = 1'b1; tick(1); rst = 1'b0;
    tick(67); enable = 1'b0; tick(3);

    check_val("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
